bit_stream_tx: RTL and testbench
================================

BIT_STREAM_TX -- requirements
Module: bit_stream_tx

Interface
REQ-001 Parameter packetSize, default 4, SHALL set the number of data bits per frame (legal range >= 2).
REQ-002 Parameter cycleDiv, default 100, SHALL set the clk cycles per serial bit period (legal range >= 2), matching the receiver's divider.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 send  input  1  SHALL be the request to transmit dIn; it is qualified by ready.
REQ-006 dIn  input  packetSize  SHALL be the parallel word to serialize.
REQ-007 ready  output  1  SHALL be high only in IDLE, meaning a request is accepted this cycle.
REQ-008 busy  output  1  SHALL be high in START, DATA and STOP.
REQ-009 txOut  output  1  SHALL be the registered serial line: idle high, start low, data LSB first, stop high.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking frame completion.
REQ-011 bitTick  output  1  SHALL be a one-cycle pulse on the last clk cycle of every bit period (debug strobe).

Function
REQ-012 States SHALL be IDLE, START, DATA and STOP, encoded in one state register.
REQ-013 Accept SHALL occur on a rising edge where ready=1 and send=1; dIn is then latched into a shift register.
REQ-014 Transition on accept SHALL be IDLE->START; txOut=0 from the cycle after the accept edge (latency 1).
REQ-015 Baud counter SHALL count 0..cycleDiv-1 in START/DATA/STOP, reset to 0 on every state entry, and hold at 0 in IDLE.
REQ-016 Terminal count (counter = cycleDiv-1) SHALL assert bitTick in that cycle and end the current bit.
REQ-017 START->DATA SHALL occur at terminal count; txOut then presents shift register bit 0.
REQ-018 In DATA, each terminal count SHALL right-shift the shift register by one and increment the bit counter (width $clog2(packetSize)).
REQ-019 DATA->STOP SHALL occur at the terminal count where bit counter = packetSize-1; txOut=1 in STOP.
REQ-020 STOP->IDLE SHALL occur at terminal count; done=1 in that same cycle.
REQ-021 Frame length SHALL be exactly (packetSize+2)*cycleDiv cycles from the first START cycle to the last STOP cycle.
REQ-022 send while busy=1 SHALL be ignored, with no queuing.
REQ-023 dIn changes after accept SHALL NOT affect the frame in progress.
REQ-024 Back-to-back frames SHALL be separated by at least one IDLE cycle (ready=1), with txOut=1 during it.
REQ-025 send held high continuously SHALL produce consecutive frames, each separated by exactly one IDLE cycle.
REQ-026 done and bitTick SHALL never assert in IDLE.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, txOut=1, ready=1 (as soon as rst_n deasserts), busy=0, done=0, bitTick=0, counters=0 and shift register=0.
REQ-028 Reset mid-frame SHALL abandon the frame; after rst_n rises, the line stays high until a new accept.
REQ-029 The first accept SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-030 packetSize=4, cycleDiv=4, send pulse with dIn=4'b1010 -> txOut 0x4, 0x4, 1x4, 0x4, 1x4, 1x4 cycles; done at cycle 24 after accept; 6 bitTicks.
REQ-031 dIn=4'b1111, then dIn changed to 0 and send pulsed at cycle 5 of the frame -> frame still shows 0,1,1,1,1,1; no second frame.
REQ-032 send held high with dIn=4'b0001 -> two frames, each 24 cycles, with exactly one cycle of ready=1/txOut=1 between them.
REQ-033 rst_n low at cycle 10 of the frame -> txOut=1 and busy=0 in the same cycle; no done; the next accept produces a full, correct frame.
REQ-034 cycleDiv=2, packetSize=8, dIn=8'h81 -> 20-cycle frame: 0,1,0,0,0,0,0,0,1,1 at 2 cycles each.

Source files
------------

// File: rtl/bit_stream_tx_if.sv
// Handshake and serial-line bundle for bit_stream_tx.
// The master drives the transmit request and word; the slave (the transmitter)
// drives the status flags, the serial line and the debug strobe.
interface bit_stream_tx_if #(
    parameter int packetSize = 4
) ();
    logic                  send;
    logic [packetSize-1:0] dIn;
    logic                  ready;
    logic                  busy;
    logic                  txOut;
    logic                  done;
    logic                  bitTick;

    modport master (
        output send,
        output dIn,
        input  ready,
        input  busy,
        input  txOut,
        input  done,
        input  bitTick
    );

    modport slave (
        input  send,
        input  dIn,
        output ready,
        output busy,
        output txOut,
        output done,
        output bitTick
    );
endinterface

// File: rtl/bit_stream_tx.sv
// Serial frame transmitter: one low start bit, packetSize data bits LSB first,
// one high stop bit, each bit lasting cycleDiv clock cycles. The serial line is
// registered so it changes together with the state register.
module bit_stream_tx #(
    parameter int packetSize = 4,
    parameter int cycleDiv   = 100
) (
    input  logic           clk,
    input  logic           rst_n,
    bit_stream_tx_if.slave bus
);
    localparam int BAUD_W = (cycleDiv > 1) ? $clog2(cycleDiv) : 1;
    localparam int BIT_W  = (packetSize > 1) ? $clog2(packetSize) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(cycleDiv - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(packetSize - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [BAUD_W-1:0]     baud;
    logic [BAUD_W-1:0]     baud_next;
    logic [BIT_W-1:0]      bit_idx;
    logic [BIT_W-1:0]      bit_idx_next;
    logic [packetSize-1:0] shift;
    logic [packetSize-1:0] shift_next;
    logic                  tx;
    logic                  tx_next;
    logic                  term;

    // Last cycle of the current bit period; never true while idle.
    assign term = (state != IDLE) && (baud == BAUD_LAST);

    assign bus.ready   = (state == IDLE);
    assign bus.busy    = (state != IDLE);
    assign bus.txOut   = tx;
    assign bus.done    = (state == STOP) && term;
    assign bus.bitTick = term;

    // State, counters, shift register and serial line register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    // Next state plus the value the line must show once that state is entered.
    always_comb begin
        state_next   = state;
        baud_next    = baud + BAUD_W'(1);
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = tx;
        unique case (state)
            IDLE: begin
                baud_next = '0;
                tx_next   = 1'b1;
                if (bus.send) begin
                    state_next   = START;
                    shift_next   = bus.dIn;
                    bit_idx_next = '0;
                    tx_next      = 1'b0;
                end
            end
            START: begin
                if (term) begin
                    state_next   = DATA;
                    baud_next    = '0;
                    bit_idx_next = '0;
                    tx_next      = shift[0];
                end
            end
            DATA: begin
                if (term) begin
                    baud_next    = '0;
                    shift_next   = shift >> 1;
                    bit_idx_next = bit_idx + BIT_W'(1);
                    if (bit_idx == BIT_LAST) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        // shift[1] becomes bit 0 after this edge's shift.
                        tx_next = shift[1];
                    end
                end
            end
            STOP: begin
                if (term) begin
                    state_next = IDLE;
                    baud_next  = '0;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
                tx_next    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_bit_stream_tx.sv
// Bench for bit_stream_tx: two instances (4 bits / 4 cycles and 8 bits /
// 2 cycles). A reference model expands every accepted word into its expected
// per-cycle line/strobe sequence; a monitor compares each cycle.
module tb_bit_stream_tx;
    typedef struct packed {
        logic tx;
        logic tick;
        logic done;
    } exp_t;

    localparam int PA = 4;
    localparam int DA = 4;
    localparam int PB = 8;
    localparam int DB = 2;

    logic clk;
    logic rst_n;

    bit_stream_tx_if #(.packetSize(PA)) bus_a ();
    bit_stream_tx_if #(.packetSize(PB)) bus_b ();

    bit_stream_tx #(.packetSize(PA), .cycleDiv(DA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    bit_stream_tx #(.packetSize(PB), .cycleDiv(DB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int   n_total = 0;
    int   n_bad   = 0;
    int   rem_a   = 0;
    int   rem_b   = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-cycle view of one frame carrying 'data'.
    task automatic build(input int p, input int d, input logic [7:0] data, output exp_t q[$]);
        logic lvl;
        q.delete();
        for (int b = 0; b < p + 2; b++) begin
            if (b == 0)      lvl = 1'b0;
            else if (b <= p) lvl = data[b-1];
            else             lvl = 1'b1;
            for (int c = 0; c < d; c++)
                q.push_back(exp_t'{tx: lvl, tick: (c == d - 1), done: (b == p + 1) && (c == d - 1)});
        end
    endtask

    // Reference model: a word is accepted when no frame is in flight.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                rem_a = 0;
                rem_b = 0;
                q_a.delete();
                q_b.delete();
            end else begin
                if (rem_a == 0) begin
                    if (bus_a.send) begin
                        build(PA, DA, 8'(bus_a.dIn), q_a);
                        rem_a = (PA + 2) * DA;
                    end
                end else begin
                    rem_a = rem_a - 1;
                end
                if (rem_b == 0) begin
                    if (bus_b.send) begin
                        build(PB, DB, bus_b.dIn, q_b);
                        rem_b = (PB + 2) * DB;
                    end
                end else begin
                    rem_b = rem_b - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from state updates.
    initial begin
        exp_t ea;
        exp_t eb;
        forever begin
            @(negedge clk);
            ea = exp_t'{tx: 1'b1, tick: 1'b0, done: 1'b0};
            eb = exp_t'{tx: 1'b1, tick: 1'b0, done: 1'b0};
            if (rem_a != 0) begin
                if (q_a.size() == 0) chk("a_queue_empty", 1'b1, 1'b0);
                else ea = q_a.pop_front();
            end
            if (rem_b != 0) begin
                if (q_b.size() == 0) chk("b_queue_empty", 1'b1, 1'b0);
                else eb = q_b.pop_front();
            end
            chk("a_busy", bus_a.busy, rem_a != 0);
            chk("a_txOut", bus_a.txOut, ea.tx);
            chk("a_bitTick", bus_a.bitTick, ea.tick);
            chk("a_done", bus_a.done, ea.done);
            chk("b_busy", bus_b.busy, rem_b != 0);
            chk("b_txOut", bus_b.txOut, eb.tx);
            chk("b_bitTick", bus_b.bitTick, eb.tick);
            chk("b_done", bus_b.done, eb.done);
            if (rst_n) begin
                chk("a_ready", bus_a.ready, rem_a == 0);
                chk("b_ready", bus_b.ready, rem_b == 0);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stimulus: directed frames followed by random traffic.
    initial begin
        rst_n       = 1'b0;
        bus_a.send  = 1'b0;
        bus_a.dIn   = '0;
        bus_b.send  = 1'b0;
        bus_b.dIn   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First accept on the first edge out of reset; 1010 and 0x81 frames.
        bus_a.send = 1'b1;
        bus_a.dIn  = 4'b1010;
        bus_b.send = 1'b1;
        bus_b.dIn  = 8'h81;
        wait_cycles(1);
        bus_a.send = 1'b0;
        bus_b.send = 1'b0;
        wait_cycles(30);

        // Word changed and send re-pulsed mid-frame must not disturb the frame.
        bus_a.dIn  = 4'b1111;
        bus_a.send = 1'b1;
        wait_cycles(1);
        bus_a.send = 1'b0;
        wait_cycles(4);
        bus_a.dIn  = 4'b0000;
        bus_a.send = 1'b1;
        wait_cycles(1);
        bus_a.send = 1'b0;
        wait_cycles(25);

        // Send held high: exactly two frames with one idle cycle between.
        bus_a.dIn  = 4'b0001;
        bus_a.send = 1'b1;
        bus_b.dIn  = 8'h3C;
        bus_b.send = 1'b1;
        wait_cycles(27);
        bus_a.send = 1'b0;
        bus_b.send = 1'b0;
        wait_cycles(30);

        // Reset at cycle 10 of a frame, then a fresh frame.
        bus_a.dIn  = 4'b1001;
        bus_a.send = 1'b1;
        wait_cycles(1);
        bus_a.send = 1'b0;
        wait_cycles(9);
        rst_n = 1'b0;
        wait_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(3);
        bus_a.dIn  = 4'b0110;
        bus_a.send = 1'b1;
        wait_cycles(1);
        bus_a.send = 1'b0;
        wait_cycles(30);

        // Random traffic on both instances.
        for (int i = 0; i < 1500; i++) begin
            bus_a.send = ($urandom_range(0, 7) == 0);
            bus_a.dIn  = 4'($urandom);
            bus_b.send = ($urandom_range(0, 3) == 0);
            bus_b.dIn  = 8'($urandom);
            wait_cycles(1);
        end
        bus_a.send = 1'b0;
        bus_b.send = 1'b0;
        wait_cycles(40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
